// File: rtl/subleq_core.sv
// subleq_core: three-operand subleq CPU core.
//   Each instruction at pc is the triple (A, B, C):
//     mem[B] <- mem[B] - mem[A]; branch to C if the signed result is <= 0,
//     otherwise fall through to pc+3. A taken branch to all-ones halts.
//   One shared instruction/data memory is accessed through a req/ack
//   handshake with arbitrary wait states.
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   enable               run enable, sampled only between instructions
//   mem_req/mem_we       request (held until ack) and write strobe
//   mem_addr/mem_wdata   word address and write data
//   mem_rdata/mem_ack    read data and transfer-complete strobe
//   halted               core stopped on the halt instruction
//   pc                   address of the current instruction
//   retired              saturating count of completed instructions
module subleq_core #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_BITS = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  output logic                mem_req,
  output logic                mem_we,
  output logic [WIDTH-1:0]    mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  input  logic [WIDTH-1:0]    mem_rdata,
  input  logic                mem_ack,
  output logic                halted,
  output logic [WIDTH-1:0]    pc,
  output logic [CNT_BITS-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE, FA, FB, FC, RA, RB, WB, HALT
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] op_a, op_b, op_c, va, vb;
  logic [WIDTH-1:0] diff;
  logic             taken;
  logic             is_halt;

  assign diff    = vb - va;
  // Signed <= 0: sign bit set or exactly zero; overflow wrap is not corrected.
  assign taken   = diff[WIDTH-1] | (diff == '0);
  assign is_halt = taken & (op_c == '1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (enable) state_next = FA;
      FA:   if (mem_ack) state_next = FB;
      FB:   if (mem_ack) state_next = FC;
      FC:   if (mem_ack) state_next = RA;
      RA:   if (mem_ack) state_next = RB;
      RB:   if (mem_ack) state_next = WB;
      WB:   if (mem_ack) state_next = is_halt ? HALT : IDLE;
      HALT: state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc      <= WIDTH'(RESET_PC);
      retired <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_c    <= '0;
      va      <= '0;
      vb      <= '0;
    end else if (mem_ack) begin
      case (state)
        FA: op_a <= mem_rdata;
        FB: op_b <= mem_rdata;
        FC: op_c <= mem_rdata;
        RA: va   <= mem_rdata;
        RB: vb   <= mem_rdata;
        WB: begin
          if (retired != '1) retired <= retired + CNT_BITS'(1);
          // On halt pc keeps pointing at the halt instruction.
          if (!taken)        pc <= pc + WIDTH'(3);
          else if (!is_halt) pc <= op_c;
        end
        default: ;
      endcase
    end
  end

  // Memory-side outputs decode purely from registered state.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      FA: begin mem_req = 1'b1; mem_addr = pc; end
      FB: begin mem_req = 1'b1; mem_addr = pc + WIDTH'(1); end
      FC: begin mem_req = 1'b1; mem_addr = pc + WIDTH'(2); end
      RA: begin mem_req = 1'b1; mem_addr = op_a; end
      RB: begin mem_req = 1'b1; mem_addr = op_b; end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = op_b;
        mem_wdata = diff;
      end
      default: ;
    endcase
  end

  assign halted = (state == HALT);

endmodule

// File: tb/tb_subleq_core.sv
// tb_subleq_core: directed bench for subleq_core.
//   dut  : WIDTH=16, RESET_PC=0, behind a memory model with programmable
//          wait states, a stall control and a forced late-ack input.
//   dut8 : WIDTH=8, RESET_PC=0xFE, CNT_BITS=2, zero-wait memory.
module tb_subleq_core;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        mem_req, mem_we, mem_ack, halted;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [31:0] retired;

  logic        reset8 = 1'b1;
  logic        enable8 = 1'b0;
  logic        req8, we8, ack8, halted8;
  logic [7:0]  addr8, wdata8, rdata8, pc8;
  logic [1:0]  retired8;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  subleq_core #(.WIDTH(16), .RESET_PC(0), .CNT_BITS(32)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .halted(halted), .pc(pc), .retired(retired)
  );

  subleq_core #(.WIDTH(8), .RESET_PC('hFE), .CNT_BITS(2)) dut8 (
    .clock(clock), .reset(reset8), .enable(enable8),
    .mem_req(req8), .mem_we(we8), .mem_addr(addr8),
    .mem_wdata(wdata8), .mem_rdata(rdata8), .mem_ack(ack8),
    .halted(halted8), .pc(pc8), .retired(retired8)
  );

  // ---------------- 16-bit memory model ----------------
  logic [15:0] img [0:255];
  logic [15:0] mem [0:255];
  int          max_wait = 0;
  int          wait_cnt = 0;
  logic        stall = 1'b0;
  logic        late_ack = 1'b0;
  logic        ack_m = 1'b0;
  logic        hold_v = 1'b0;
  logic [15:0] h_addr, h_wdata;
  logic        h_we;
  logic [15:0] last_waddr = '0, last_wdata = '0;
  int          wcount = 0;

  assign mem_ack = ack_m | late_ack;

  always @(negedge clock) begin
    ack_m     = mem_req && (wait_cnt == 0) && !stall;
    mem_rdata = mem[mem_addr[7:0]];
  end

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] = img[i];
      hold_v = 1'b0;
    end else begin
      if (hold_v && mem_req) begin
        checks++;
        assert (mem_addr === h_addr && mem_we === h_we && mem_wdata === h_wdata) else begin
          errors++;
          $error("FAIL hold_stable: got addr=%0h we=%0b wdata=%0h expected addr=%0h we=%0b wdata=%0h",
                 mem_addr, mem_we, mem_wdata, h_addr, h_we, h_wdata);
        end
      end
      if (mem_req && mem_ack) begin
        if (mem_we) begin
          mem[mem_addr[7:0]] = mem_wdata;
          last_waddr = mem_addr;
          last_wdata = mem_wdata;
          wcount++;
        end
        hold_v   = 1'b0;
        wait_cnt = $urandom_range(0, max_wait);
      end else if (mem_req) begin
        hold_v  = 1'b1;
        h_addr  = mem_addr;
        h_we    = mem_we;
        h_wdata = mem_wdata;
        if (wait_cnt > 0) wait_cnt--;
      end
    end
  end

  // ---------------- 8-bit memory model ----------------
  logic [7:0] img8 [0:255];
  logic [7:0] mem8 [0:255];
  logic [7:0] log8 [0:63];
  int         n8 = 0;
  logic [7:0] lw8_addr = '0, lw8_data = '0;

  assign ack8   = 1'b1;
  assign rdata8 = mem8[addr8];

  always @(posedge clock) begin
    if (reset8) begin
      for (int i = 0; i < 256; i++) mem8[i] = img8[i];
      n8 = 0;
    end else if (req8) begin
      if (n8 < 64) begin
        log8[n8] = addr8;
        n8++;
      end
      if (we8) begin
        mem8[addr8] = wdata8;
        lw8_addr = addr8;
        lw8_data = wdata8;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = '0;
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] m [0:255];
  int          steps;
  int          pcm;
  int          wsave;
  logic [15:0] ra, rb, rc, rr;

  initial begin
    for (int i = 0; i < 256; i++) img8[i] = '0;
    img8[8'hFE] = 8'h10;
    img8[8'hFF] = 8'h11;
    img8[8'h00] = 8'h40;
    img8[8'h10] = 8'h01;
    img8[8'h11] = 8'h80;

    // T1: taken branch, write of -3
    clear_img();
    img[0] = 16'd3; img[1] = 16'd4; img[2] = 16'd6; img[3] = 16'd5; img[4] = 16'd2;
    reset = 1'b1;
    tick();
    chk("rst_req",     {31'd0, mem_req}, 32'd0);
    chk("rst_we",      {31'd0, mem_we}, 32'd0);
    chk("rst_addr",    {16'd0, mem_addr}, 32'd0);
    chk("rst_wdata",   {16'd0, mem_wdata}, 32'd0);
    chk("rst_pc",      {16'd0, pc}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_halted",  {31'd0, halted}, 32'd0);
    reset = 1'b0; enable = 1'b1;
    repeat (6) tick();
    chk("t1_wb_req",     {31'd0, mem_req}, 32'd1);
    chk("t1_wb_we",      {31'd0, mem_we}, 32'd1);
    chk("t1_wb_addr",    {16'd0, mem_addr}, 32'd4);
    chk("t1_wb_wdata",   {16'd0, mem_wdata}, 32'hFFFD);
    chk("t1_retired_c6", retired, 32'd0);
    tick();
    chk("t1_retired", retired, 32'd1);
    chk("t1_pc",      {16'd0, pc}, 32'd6);
    chk("t1_waddr",   {16'd0, last_waddr}, 32'd4);
    chk("t1_wdata",   {16'd0, last_wdata}, 32'hFFFD);
    chk("t1_idle_req", {31'd0, mem_req}, 32'd0);

    // T2: branch not taken
    img[4] = 16'd9;
    reset = 1'b1; enable = 1'b0;
    tick();
    reset = 1'b0; enable = 1'b1;
    repeat (7) tick();
    chk("t2_waddr",   {16'd0, last_waddr}, 32'd4);
    chk("t2_wdata",   {16'd0, last_wdata}, 32'd4);
    chk("t2_pc",      {16'd0, pc}, 32'd3);
    chk("t2_retired", retired, 32'd1);

    // T3: halt instruction clears mem[3]
    clear_img();
    img[0] = 16'd3; img[1] = 16'd3; img[2] = 16'hFFFF; img[3] = 16'd7;
    reset = 1'b1; enable = 1'b0;
    tick();
    reset = 1'b0; enable = 1'b1;
    repeat (7) tick();
    chk("t3_waddr",   {16'd0, last_waddr}, 32'd3);
    chk("t3_wdata",   {16'd0, last_wdata}, 32'd0);
    chk("t3_halted",  {31'd0, halted}, 32'd1);
    chk("t3_req",     {31'd0, mem_req}, 32'd0);
    chk("t3_pc",      {16'd0, pc}, 32'd0);
    chk("t3_retired", retired, 32'd1);
    wsave = wcount;
    repeat (100) tick();
    chk("t3_hold_halted",  {31'd0, halted}, 32'd1);
    chk("t3_hold_req",     {31'd0, mem_req}, 32'd0);
    chk("t3_hold_pc",      {16'd0, pc}, 32'd0);
    chk("t3_hold_retired", retired, 32'd1);
    chk("t3_hold_writes",  wcount, wsave);

    // T4: 20-instruction countdown loop under random wait states
    clear_img();
    img[0] = 16'd10; img[1] = 16'd11; img[2] = 16'd6;
    img[3] = 16'd12; img[4] = 16'd12; img[5] = 16'd0;
    img[6] = 16'd12; img[7] = 16'd12; img[8] = 16'hFFFF;
    img[10] = 16'd1; img[11] = 16'd10; img[12] = 16'd0;
    for (int i = 0; i < 256; i++) m[i] = img[i];
    steps = 0; pcm = 0;
    while (steps < 200) begin
      ra = m[pcm[7:0]];
      rb = m[8'(pcm + 1)];
      rc = m[8'(pcm + 2)];
      rr = m[rb[7:0]] - m[ra[7:0]];
      m[rb[7:0]] = rr;
      steps++;
      if ($signed(rr) <= 0) begin
        if (rc == 16'hFFFF) break;
        pcm = int'(rc);
      end else begin
        pcm = pcm + 3;
      end
    end
    max_wait = 5;
    reset = 1'b1; enable = 1'b0;
    tick();
    reset = 1'b0; enable = 1'b1;
    for (int i = 0; i < 5000 && !halted; i++) tick();
    chk("t4_halted",  {31'd0, halted}, 32'd1);
    chk("t4_retired", retired, steps);
    chk("t4_pc",      {16'd0, pc}, 32'd6);
    for (int i = 0; i < 16; i++) chk($sformatf("t4_mem%0d", i), {16'd0, mem[i]}, {16'd0, m[i]});
    max_wait = 0;

    // T5: 8-bit core, pc wrap and signed overflow, saturating counter
    reset8 = 1'b0; enable8 = 1'b1;
    repeat (7) tick();
    chk("t5_fetch_a",  {24'd0, log8[0]}, 32'hFE);
    chk("t5_fetch_b",  {24'd0, log8[1]}, 32'hFF);
    chk("t5_fetch_c",  {24'd0, log8[2]}, 32'h00);
    chk("t5_read_a",   {24'd0, log8[3]}, 32'h10);
    chk("t5_read_b",   {24'd0, log8[4]}, 32'h11);
    chk("t5_waddr",    {24'd0, lw8_addr}, 32'h11);
    chk("t5_wdata",    {24'd0, lw8_data}, 32'h7F);
    chk("t5_pc",       {24'd0, pc8}, 32'h01);
    chk("t5_retired",  {30'd0, retired8}, 32'd1);
    repeat (28) tick();
    chk("t5_saturate", {30'd0, retired8}, 32'd3);
    chk("t5_pc_loop",  {24'd0, pc8}, 32'h00);

    // T6: enable drop at boundary, reset during a stalled RB
    clear_img();
    img[0] = 16'd3; img[1] = 16'd4; img[2] = 16'd6; img[3] = 16'd5; img[4] = 16'd2;
    reset = 1'b1; enable = 1'b0;
    tick();
    reset = 1'b0; enable = 1'b1;
    tick();
    enable = 1'b0;
    repeat (6) tick();
    repeat (5) tick();
    chk("t6_idle_req",     {31'd0, mem_req}, 32'd0);
    chk("t6_idle_retired", retired, 32'd1);
    chk("t6_idle_pc",      {16'd0, pc}, 32'd6);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    repeat (4) tick();
    stall = 1'b1;
    chk("t6_rb_req",  {31'd0, mem_req}, 32'd1);
    chk("t6_rb_addr", {16'd0, mem_addr}, 32'd0);
    repeat (2) tick();
    wsave = wcount;
    reset = 1'b1; stall = 1'b0;
    tick();
    reset = 1'b0; late_ack = 1'b1;
    chk("t6_rst_req",     {31'd0, mem_req}, 32'd0);
    chk("t6_rst_pc",      {16'd0, pc}, 32'd0);
    chk("t6_rst_retired", retired, 32'd0);
    tick();
    late_ack = 1'b0;
    chk("t6_late_req",     {31'd0, mem_req}, 32'd0);
    chk("t6_late_pc",      {16'd0, pc}, 32'd0);
    chk("t6_late_retired", retired, 32'd0);
    chk("t6_late_halted",  {31'd0, halted}, 32'd0);
    chk("t6_late_writes",  wcount, wsave);
    repeat (3) tick();
    chk("t6_still_idle",   {31'd0, mem_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/subleq_core.md
# subleq_core

Parametrised subleq one-instruction CPU core: the successor to the single-bit prototype, with full three-operand semantics, mem[B] ← mem[B] − mem[A], branch to C if the result ≤ 0. It drives one shared instruction/data memory through a variable-latency req/ack handshake, detects a halt instruction and counts retired instructions. It sits between the memory model or SRAM wrapper and the test or system harness.

## Interface
- WIDTH, 16: data and address width in bits (≥ 4).
- RESET_PC, 0: pc value after reset.
- CNT_BITS, 32: width of the retired-instruction counter.

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  instruction-boundary run enable.
- mem_req  out  1  memory request, held until acked.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  WIDTH  word address.
- mem_wdata  out  WIDTH  write data; valid when mem_we = 1.
- mem_rdata  in  WIDTH  read data; sampled on the ack edge.
- mem_ack  in  1  transfer complete; ignored while mem_req = 0.
- halted  out  1  core has stopped on the halt instruction.
- pc  out  WIDTH  address of the current instruction.
- retired  out  CNT_BITS  completed instructions; saturates at all-ones.

## Operation
- States: IDLE, FA (read pc), FB (read pc+1), FC (read pc+2), RA (read mem[A]), RB (read mem[B]), WB (write mem[B]), HALT.
- IDLE: mem_req = 0. Go to FA when enable = 1. enable is only sampled in IDLE; clearing it mid-instruction takes effect at the next boundary.
- FA, FB and FC latch operands A, B and C from mem_rdata on their ack. RA latches va and RB latches vb.
- WB writes mem_wdata = vb − va to mem_addr = B.
  - The subtraction is modulo 2^WIDTH, two's complement.
  - Branch condition: the result, taken as signed, is ≤ 0. Negative or zero branches; overflow wrap is not corrected.
- On the WB ack:
  - retired increments, saturating.
  - Branch taken and C = all-ones: go to HALT. pc holds its old value and the write still happens.
  - Branch taken otherwise: pc ← C.
  - Branch not taken: pc ← pc + 3.
  - Next state is IDLE.
- pc+1, pc+2 and pc+3 wrap modulo 2^WIDTH. For example, pc = 2^WIDTH−1 fetches B from address 0.
- HALT: mem_req = 0 and halted = 1. Only reset leaves HALT.
- In read states mem_we = 0. mem_wdata is don't-care outside WB; drive it 0.

## Timing
- All outputs decode from registered state only. There is no combinational path from mem_ack, mem_rdata or enable to any output.
- Handshake:
  - While mem_req = 1, mem_we, mem_addr and mem_wdata are stable until the rising edge where mem_ack = 1. That edge completes the transfer.
  - On the next cycle either mem_req is asserted again for the following state, or it drops (IDLE or HALT).
- Zero-wait memory (mem_ack tied high): each access takes 1 cycle. One instruction takes 7 cycles: IDLE + 6 accesses.
- Each wait cycle (mem_ack = 0) adds exactly 1 cycle.
- Reset values on the edge where reset = 1:
  - state = IDLE, pc = RESET_PC, retired = 0, halted = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - Operand registers are set to 0.
- Reset mid-transaction abandons the transfer. mem_req is 0 from the next cycle, and a late ack is ignored.
- Reset wins over any simultaneous ack or enable.

## Test plan
- Zero-wait memory, WIDTH = 16. mem[0..2] = 3, 4, 6; mem[3] = 5; mem[4] = 2. → Write of −3 (0xFFFD) to address 4, pc = 6, retired = 1, 7 cycles from leaving reset.
- Same program with mem[4] = 9. → Write of 4, branch not taken, pc = 3.
- Halt: mem[0..2] = 3, 3, 0xFFFF (clears mem[3]). → Write of 0 to address 3, halted = 1 and mem_req = 0 from the next cycle, pc = 0, retired = 1, and the state holds for 100 cycles.
- Random 0–5 cycle ack delays on a 20-instruction loop program. → Memory image and retired count match a reference model, and the address/data stability assertion holds on every request.
- WIDTH = 8 with pc at 0xFE and an overflow case vb = 0x80, va = 0x01. → Operands are fetched from 0xFE, 0xFF and 0x00; the result 0x7F is positive so the branch is not taken and pc = 0x01.
- enable = 0 after the first instruction; reset asserted during RB with ack pending. → The core idles with mem_req = 0. After reset, pc = RESET_PC, retired = 0, and the late ack causes no state change.
